// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: state codes, SCK divide encodings,
// the half-period helper and the default sizes.
package spi_pkg;

  localparam int DW_DEF  = 8;
  localparam int NSS_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [1:0] CDIV_4  = 2'd0;
  localparam logic [1:0] CDIV_8  = 2'd1;
  localparam logic [1:0] CDIV_16 = 2'd2;
  localparam logic [1:0] CDIV_32 = 2'd3;

  // SCK half-period in clk cycles, i.e. 2 << cdiv
  function automatic logic [4:0] half_period(input logic [1:0] cdiv);
    case (cdiv)
      CDIV_4:  return 5'd2;
      CDIV_8:  return 5'd4;
      CDIV_16: return 5'd8;
      CDIV_32: return 5'd16;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_ss16_ss_decoder.sv
// Combinational address to active-low slave-select decoder; all lines
// stay high when en is low or the address matches no line.
module ss_decoder #(
  parameter int NSS = 16,
  parameter int AW  = 4
) (
  input  logic [AW-1:0]  addr,
  input  logic           en,
  output logic [NSS-1:0] ss
);

  for (genvar i = 0; i < NSS; i++) begin : g_sel
    assign ss[i] = ~(en && (addr == AW'(i)));
  end

endmodule

// File: rtl/spi_master_ss16.sv
// SPI mode-0 byte master driving one of NSS active-low slave selects.
// Define SPI_MASTER_RX_EN to build the receive path; otherwise rdata is 0.
module spi_master_ss16
  import spi_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NSS = NSS_DEF,
  parameter int AW  = $clog2(NSS)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           start,
  input  logic           mlb,
  input  logic [1:0]     cdiv,
  input  logic [DW-1:0]  tdat,
  input  logic [AW-1:0]  addr,
  input  logic           din,
  output logic           sck,
  output logic           dout,
  output logic [NSS-1:0] ss,
  output logic           done,
  output logic           busy,
  output logic [DW-1:0]  rdata
);

  localparam int BW = $clog2(DW + 1);

  logic [1:0]    state;
  logic [DW-1:0] tx_sr;
  logic          mlb_q;
  logic [1:0]    cdiv_q;
  logic [AW-1:0] addr_q;
  logic [4:0]    div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_tick;

  assign half_tick = (div_cnt == half_period(cdiv_q) - 5'd1);

  // The slave select is live for exactly as long as busy is high
  ss_decoder #(.NSS(NSS), .AW(AW)) u_dec (
    .addr (addr_q),
    .en   (busy),
    .ss   (ss)
  );

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state   <= ST_IDLE;
      tx_sr   <= '0;
      mlb_q   <= 1'b0;
      cdiv_q  <= CDIV_4;
      addr_q  <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      dout    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr   <= tdat;
            mlb_q   <= mlb;
            cdiv_q  <= cdiv;
            addr_q  <= addr;
            dout    <= mlb ? tdat[DW-1] : tdat[0];
            busy    <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
            sck     <= 1'b0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!half_tick) begin
            div_cnt <= div_cnt + 5'd1;
          end else begin
            div_cnt <= '0;
            sck     <= ~sck;
            // Rising edge counts a bit; falling edge either ends or advances
            if (!sck) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == BW'(DW)) begin
              state <= ST_FINISH;
            end else begin
              tx_sr <= mlb_q ? (tx_sr << 1) : (tx_sr >> 1);
              dout  <= mlb_q ? tx_sr[DW-2] : tx_sr[1];
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          dout  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DW-1:0] rx_sr;

  // Receive order mirrors transmit order so loopback returns tdat
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      rx_sr <= '0;
      rdata <= '0;
    end else if (state == ST_IDLE && start) begin
      rx_sr <= '0;
    end else if (state == ST_SEND && half_tick && !sck) begin
      rx_sr <= mlb_q ? {rx_sr[DW-2:0], din} : {din, rx_sr[DW-1:1]};
    end else if (state == ST_FINISH) begin
      rdata <= rx_sr;
    end
  end
`else
  logic unused_din;
  assign unused_din = din;
  assign rdata      = '0;
`endif

endmodule

// File: tb/tb_spi_master_ss16.sv
// Directed self-checking bench for spi_master_ss16: loopback and slave-model
// transfers, divide ratios, ignored start while busy and mid-transfer reset.
module tb_spi_master_ss16;

`ifdef SPI_MASTER_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic        mlb;
  logic [1:0]  cdiv;
  logic [7:0]  tdat;
  logic [3:0]  addr;
  logic        din;
  logic        sck;
  logic        dout;
  logic [15:0] ss;
  logic        done;
  logic        busy;
  logic [7:0]  rdata;

  logic        loopback;
  logic        slave_msb;
  logic [7:0]  resp;
  logic        slave_bit;
  logic        sck_d;
  int          cap_cnt;
  logic [7:0]  cap_bits;
  time         rise_t[2];
  int          done_cnt;
  int          checks;
  int          passes;
  int          base_done;

  always #5 clk = ~clk;

  spi_master_ss16 dut (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .mlb   (mlb),
    .cdiv  (cdiv),
    .tdat  (tdat),
    .addr  (addr),
    .din   (din),
    .sck   (sck),
    .dout  (dout),
    .ss    (ss),
    .done  (done),
    .busy  (busy),
    .rdata (rdata)
  );

  // Slave presents bit k of its response before the k-th SCK rise
  assign slave_bit = (cap_cnt > 7) ? 1'b0 :
                     (slave_msb ? resp[7 - cap_cnt] : resp[cap_cnt]);
  assign din = loopback ? dout : slave_bit;

  // Capture MOSI on every SCK rise and time the first two rises
  always @(posedge clk) begin
    sck_d <= sck;
    if (done) done_cnt <= done_cnt + 1;
    if (!busy) begin
      cap_cnt <= 0;
    end else if (sck && !sck_d) begin
      cap_bits <= {cap_bits[6:0], dout};
      if (cap_cnt < 2) rise_t[cap_cnt] <= $time;
      cap_cnt <= cap_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic m, input logic [1:0] cd,
                               input logic [7:0] td, input logic lb, input logic [7:0] rsp,
                               input logic [15:0] exp_ss, input logic [7:0] exp_seq,
                               input int exp_done, input int exp_per, input logic [7:0] exp_rd,
                               input int pulse_at, input string tag);
    int n;
    bit got;
    @(negedge clk);
    addr = a; mlb = m; cdiv = cd; tdat = td; loopback = lb; resp = rsp; slave_msb = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, " busy@0"}, 32'(busy), 32'd1);
    checkOutput({tag, " ss@0"}, 32'(ss), 32'(exp_ss));
    checkOutput({tag, " dout@0"}, 32'(dout), 32'(exp_seq[7]));
    n = 0;
    got = 1'b0;
    while (n < 600 && !got) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
      if (n == exp_done / 2) checkOutput({tag, " ss mid"}, 32'(ss), 32'(exp_ss));
      if (done) got = 1'b1;
    end
    start = 1'b0;
    checkOutput({tag, " done edge"}, 32'(n), 32'(exp_done));
    checkOutput({tag, " rdata"}, 32'(rdata), 32'(RX_ON ? exp_rd : 8'h00));
    checkOutput({tag, " mosi seq"}, 32'(cap_bits), 32'(exp_seq));
    checkOutput({tag, " sck period"}, 32'((rise_t[1] - rise_t[0]) / 10), 32'(exp_per));
    checkOutput({tag, " ss idle"}, 32'(ss), 32'hFFFF);
    checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    checks = 0; passes = 0; done_cnt = 0;
    rstb = 1'b1; start = 1'b0; mlb = 1'b1; cdiv = 2'd0; tdat = 8'h00; addr = 4'd0;
    loopback = 1'b1; slave_msb = 1'b1; resp = 8'h00; sck_d = 1'b0; cap_cnt = 0; cap_bits = 8'h00;
    rise_t[0] = 0; rise_t[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst sck", 32'(sck), 32'd0);
    checkOutput("rst dout", 32'(dout), 32'd0);
    checkOutput("rst ss", 32'(ss), 32'hFFFF);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rstb = 1'b0;

    applyStimulus(4'd0, 1'b1, 2'd0, 8'h7C, 1'b1, 8'h00, 16'hFFFE, 8'h7C, 33, 4, 8'h7C, 0, "lb7c");
    applyStimulus(4'd1, 1'b1, 2'd1, 8'h1C, 1'b0, 8'hAC, 16'hFFFD, 8'h1C, 65, 8, 8'hAC, 0, "slvmsb");
    applyStimulus(4'd2, 1'b0, 2'd1, 8'h1C, 1'b0, 8'hAC, 16'hFFFB, 8'h38, 65, 8, 8'hAC, 0, "slvlsb");
    applyStimulus(4'd5, 1'b1, 2'd3, 8'hE3, 1'b1, 8'h00, 16'hFFDF, 8'hE3, 257, 32, 8'hE3, 0, "lbe3");

    base_done = done_cnt;
    applyStimulus(4'd5, 1'b1, 2'd3, 8'hE3, 1'b1, 8'h00, 16'hFFDF, 8'hE3, 257, 32, 8'hE3, 100, "busystart");
    repeat (300) @(posedge clk);
    #1;
    checkOutput("busystart done count", 32'(done_cnt - base_done), 32'd1);
    checkOutput("busystart idle", 32'(busy), 32'd0);

    base_done = done_cnt;
    @(negedge clk);
    addr = 4'd3; mlb = 1'b1; cdiv = 2'd0; tdat = 8'h5A; loopback = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("abort busy before", 32'(busy), 32'd1);
    rstb = 1'b1;
    #1;
    checkOutput("abort sck", 32'(sck), 32'd0);
    checkOutput("abort dout", 32'(dout), 32'd0);
    checkOutput("abort ss", 32'(ss), 32'hFFFF);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rdata", 32'(rdata), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort no done", 32'(done_cnt - base_done), 32'd0);
    @(negedge clk);
    rstb = 1'b0;

    applyStimulus(4'd15, 1'b1, 2'd0, 8'hA5, 1'b1, 8'h00, 16'h7FFF, 8'hA5, 33, 4, 8'hA5, 0, "postrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
